// File: rtl/prog_seq_pkg.sv
// Shared types and constants for the program sequencer.
package prog_seq_pkg;

  localparam int CYC_W = 16;

  localparam logic [1:0] PROG_1 = 2'b00;
  localparam logic [1:0] PROG_2 = 2'b01;
  localparam logic [1:0] PROG_3 = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    INIT = 2'b01,
    RUN  = 2'b10,
    DONE = 2'b11
  } state_t;

  // Next program select, wrapping to PROG_1 after the last implemented program.
  function automatic logic [1:0] next_prog(input logic [1:0] cur, input int num_progs);
    logic [1:0] nxt;
    nxt = PROG_1;
    case (cur)
      PROG_1:  nxt = (num_progs > 1) ? PROG_2 : PROG_1;
      PROG_2:  nxt = (num_progs > 2) ? PROG_3 : PROG_1;
      default: nxt = PROG_1;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/prog_seq_cycle_ctr.sv
// Saturating up-counter with synchronous clear (priority) and count enable.
module prog_seq_cycle_ctr
  import prog_seq_pkg::*;
#(
  parameter int W = CYC_W
) (
  input  logic         CLK,
  input  logic         Reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/prog_sequencer.sv
// Program sequencer: Req/Ack handshake, program select, Init hold and run-cycle count.
// Optional watchdog on RUN length is enabled with `define PROG_SEQ_TIMEOUT_EN.
//
//   state | meaning
//   IDLE  | after reset, core held in Init, waiting for a Req rising edge
//   INIT  | Init held for INIT_CYCLES cycles before the program runs
//   RUN   | core running, cycles counted, waiting for Halt (or watchdog)
//   DONE  | program complete, Ack high, core frozen until the next start
module prog_sequencer
  import prog_seq_pkg::*;
#(
  parameter int INIT_CYCLES    = 2,
  parameter int NUM_PROGS      = 3,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Req,
  input  logic             Halt,
  output logic             Init,
  output logic [1:0]       ProgState,
  output logic             Running,
  output logic             Ack,
  output logic             TimedOut,
  output logic [CYC_W-1:0] CycleCount
);

  if (INIT_CYCLES < 1 || INIT_CYCLES > 15) begin : g_bad_init
    $error("INIT_CYCLES out of range 1..15");
  end
  if (NUM_PROGS < 1 || NUM_PROGS > 3) begin : g_bad_progs
    $error("NUM_PROGS out of range 1..3");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES out of range 1..65535");
  end

  localparam logic [3:0] INIT_LOAD = 4'(INIT_CYCLES - 1);

  state_t     state;
  state_t     state_nxt;
  logic       req_q;
  logic       start;
  logic [3:0] init_cnt;
  logic [3:0] init_cnt_nxt;
  logic [1:0] prog_nxt;
  logic       clr_cyc;
  logic       en_cyc;
  logic       timeout_hit;
  logic       timed_out_nxt;

  assign start = Req & ~req_q;

`ifdef PROG_SEQ_TIMEOUT_EN
  localparam logic [CYC_W-1:0] TO_LAST = CYC_W'(TIMEOUT_CYCLES - 1);
  // Count reaches TIMEOUT_CYCLES on the edge that this compare fires.
  assign timeout_hit = (CycleCount >= TO_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_nxt     = state;
    init_cnt_nxt  = init_cnt;
    prog_nxt      = ProgState;
    clr_cyc       = 1'b0;
    en_cyc        = 1'b0;
    timed_out_nxt = TimedOut;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt     = INIT;
          init_cnt_nxt  = INIT_LOAD;
          clr_cyc       = 1'b1;
          timed_out_nxt = 1'b0;
        end
      end
      INIT: begin
        if (init_cnt == 4'd0) begin
          state_nxt = RUN;
        end else begin
          init_cnt_nxt = init_cnt - 4'd1;
        end
      end
      RUN: begin
        en_cyc = 1'b1;
        if (Halt) begin
          state_nxt = DONE;
        end else if (timeout_hit) begin
          state_nxt     = DONE;
          timed_out_nxt = 1'b1;
        end
      end
      DONE: begin
        if (start) begin
          state_nxt     = INIT;
          init_cnt_nxt  = INIT_LOAD;
          clr_cyc       = 1'b1;
          timed_out_nxt = 1'b0;
          prog_nxt      = next_prog(ProgState, NUM_PROGS);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they change with the state.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      init_cnt  <= 4'd0;
      req_q     <= 1'b0;
      ProgState <= PROG_1;
      Init      <= 1'b1;
      Running   <= 1'b0;
      Ack       <= 1'b0;
      TimedOut  <= 1'b0;
    end else begin
      state     <= state_nxt;
      init_cnt  <= init_cnt_nxt;
      req_q     <= Req;
      ProgState <= prog_nxt;
      Init      <= (state_nxt != RUN);
      Running   <= (state_nxt == RUN);
      Ack       <= (state_nxt == DONE);
      TimedOut  <= timed_out_nxt;
    end
  end

  prog_seq_cycle_ctr #(
    .W(CYC_W)
  ) u_cycle_ctr (
    .CLK  (CLK),
    .Reset(Reset),
    .clr  (clr_cyc),
    .en   (en_cyc),
    .count(CycleCount)
  );

endmodule
